// File: rtl/serial_adder_fsm.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_fsm
// Brief    : Bit-serial ripple adder, one full-adder cell reused LSB first.
//            Optional subtract mode enabled by macro SERIAL_ADDER_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_load;
    logic               w_shift;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;
    logic               w_bit;
    logic               w_carry;
    logic [WIDTH-1:0]   w_sum_shift;

    // Subtraction is a + ~b + 1, so only the B load value and initial carry change.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    assign w_bit   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_shift = w_bit;
        end else begin : g_sum_wn
            assign w_sum_shift = {w_bit, r_sum[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_shift = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_a     <= a;
                r_b     <= w_b_load;
                r_carry <= w_c_load;
                r_cnt   <= '0;
            end
            if (w_shift) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_carry <= w_carry;
                r_cnt   <= r_cnt + c_cnt_w'(1);
                r_sum   <= w_sum_shift;
            end
            if (w_last) begin
                r_cout <= w_carry;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_fsm
// Brief    : Self-checking bench for serial_adder_fsm (WIDTH=8 and WIDTH=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder_fsm #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_fsm #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (1'b0),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return s[8:0];
    endfunction

    // One WIDTH=8 operation; returns result, done latency and busy-cycle count.
    task automatic do_op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                          output logic [8:0] got, output int done_k, output int busy_n);
        @(negedge clk);
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        got = '0; done_k = -1; busy_n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy8) busy_n++;
            if (done8) begin
                done_k = k;
                got = {cout8, sum8};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_w8: got busy=%b done=%b cout=%b sum=%h, expected all 0", busy8, done8, cout8, sum8);
        end
        n_checks++;
        if ({busy1, done1, cout1, sum1} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_w1: got busy=%b done=%b cout=%b sum=%b, expected all 0", busy1, done1, cout1, sum1);
        end
        start8 = 1'b0; start1 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b after reset release with start low, expected 0", busy8);
        end
    endtask

    task automatic test_width1_exhaustive();
        int done_k;
        logic [1:0] exp;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); start1 = 1'b1;
            exp = 2'(((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1));
            @(posedge clk);
            #1;
            start1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
            done_k = -1;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (done1) begin
                    done_k = k;
                    break;
                end
            end
            n_checks++;
            if (done_k !== 2) begin
                n_fail++;
                $display("FAIL w1_latency[%0d]: done at cycle %0d, expected 2", i, done_k);
            end
            n_checks++;
            if ({cout1, sum1} !== exp) begin
                n_fail++;
                $display("FAIL w1_result[%0d]: got {cout,sum}=%b, expected %b", i, {cout1, sum1}, exp);
            end
        end
    endtask

    task automatic test_timing();
        logic [8:0] got;
        int done_k, busy_n;
        do_op8(8'hFF, 8'h01, 1'b0, got, done_k, busy_n);
        n_checks++;
        if (got !== 9'h100) begin
            n_fail++;
            $display("FAIL ff_plus_01: got %h, expected 100", got);
        end
        n_checks++;
        if (done_k !== 9) begin
            n_fail++;
            $display("FAIL done_latency: done at cycle %0d, expected 9", done_k);
        end
        n_checks++;
        if (busy_n !== 8) begin
            n_fail++;
            $display("FAIL busy_cycles: busy for %0d cycles, expected 8", busy_n);
        end
    endtask

    task automatic test_random();
        logic [8:0] got, exp;
        logic [7:0] x, y;
        logic c;
        int done_k, busy_n;
        for (int i = 0; i < 16; i++) begin
            x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
            if (i == 0) begin x = 8'h00; y = 8'h00; c = 1'b0; end
            if (i == 1) begin x = 8'hFF; y = 8'hFF; c = 1'b1; end
            exp = ref_add8(x, y, c);
            do_op8(x, y, c, got, done_k, busy_n);
            n_checks++;
            if (got !== exp || done_k !== 9) begin
                n_fail++;
                $display("FAIL random_add[%0d]: %h+%h+%b got %h at cycle %0d, expected %h at cycle 9",
                         i, x, y, c, got, done_k, exp);
            end
        end
    endtask

    task automatic test_ignored_start();
        int dones;
        logic [8:0] got;
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        dones = 0; got = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (done8) begin
                dones++;
                got = {cout8, sum8};
            end
            if (k == 3) begin
                start8 = 1'b1; a8 = 8'h55;
            end else begin
                start8 = 1'b0;
            end
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL ignored_start_dones: %0d done pulses, expected 1", dones);
        end
        n_checks++;
        if (got !== ref_add8(8'h0F, 8'h01, 1'b0)) begin
            n_fail++;
            $display("FAIL ignored_start_result: got %h, expected %h", got, ref_add8(8'h0F, 8'h01, 1'b0));
        end
        n_checks++;
        if ({busy8, cout8, sum8} !== {1'b0, 9'h010}) begin
            n_fail++;
            $display("FAIL ignored_start_hold: busy=%b {cout,sum}=%h, expected busy=0 010", busy8, {cout8, sum8});
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] got;
        int done_k, busy_n;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int k = 1; k <= 4; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b cout=%b sum=%h, expected all 0", busy8, done8, cout8, sum8);
        end
        do_op8(8'h12, 8'h34, 1'b0, got, done_k, busy_n);
        n_checks++;
        if (got !== 9'h046 || done_k !== 9) begin
            n_fail++;
            $display("FAIL after_reset_op: got %h at cycle %0d, expected 046 at cycle 9", got, done_k);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va[40];
        logic [7:0] vb[40];
        logic       vc[40];
        logic       exp_done;
        logic [8:0] exp;
        @(negedge clk);
        for (int s = 0; s < 40; s++) begin
            // Captures every 10 edges from s=0; done in the 9th cycle after each capture.
            if (s > 0) begin
                exp_done = (s % 10 == 9);
                n_checks++;
                if (done8 !== exp_done) begin
                    n_fail++;
                    $display("FAIL b2b_done[%0d]: done=%b, expected %b", s, done8, exp_done);
                end
                if (exp_done) begin
                    exp = ref_add8(va[s-9], vb[s-9], vc[s-9]);
                    n_checks++;
                    if ({cout8, sum8} !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_result[%0d]: got %h, expected %h", s, {cout8, sum8}, exp);
                    end
                end
            end
            va[s] = 8'($urandom); vb[s] = 8'($urandom); vc[s] = 1'($urandom);
            a8 = va[s]; b8 = vb[s]; cin8 = vc[s]; start8 = 1'b1;
            @(negedge clk);
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [8:0] got;
        int done_k, busy_n;
        sub8 = 1'b1;
        do_op8(8'h05, 8'h07, 1'b1, got, done_k, busy_n);
        n_checks++;
        if (got !== 9'h0FE) begin
            n_fail++;
            $display("FAIL sub_05_07: got %h, expected 0FE", got);
        end
        do_op8(8'h07, 8'h05, 1'b0, got, done_k, busy_n);
        n_checks++;
        if (got !== 9'h102) begin
            n_fail++;
            $display("FAIL sub_07_05: got %h, expected 102", got);
        end
        sub8 = 1'b0;
    endtask
`endif

    initial begin
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
`endif
        test_reset();
        test_width1_exhaustive();
        test_timing();
        test_random();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
